mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM stage of the in-order pipeline: sits between the EX/MEM register and the MEM/WB register.
- Drives mem_rd_data/mem_rd_addr/mem_rd_enable/mem_stall into MEM/WB.
- Executes loads/stores as a byte-serial sequence over the 8-bit memory-controller port; assembles little-endian words and sign/zero-extends.
- Non-memory instructions pass through combinationally with no stall.

Parameters:
ADDR_WIDTH, 32, width of byte address to the memory controller

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
ex_rd_data  in  32  ALU result (non-memory ops)
ex_rd_addr  in  5  destination register
ex_rd_enable  in  1  destination write enable
ex_mem_op  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as none
ex_mem_addr  in  ADDR_WIDTH  effective byte address
ex_store_data  in  32  store source (rs2)
mem_rd_data  out  32  result to MEM/WB
mem_rd_addr  out  5  destination to MEM/WB
mem_rd_enable  out  1  write enable to MEM/WB
mem_stall  out  1  holds upstream stages; MEM/WB suppresses write while high
mc_req  out  1  byte request, level, registered
mc_we  out  1  1 write, 0 read, registered
mc_addr  out  ADDR_WIDTH  byte address, registered
mc_wdata  out  8  write byte, registered
mc_rdata  in  8  read byte, valid when mc_done=1
mc_done  in  1  one-cycle pulse completing current byte

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, byte idx=0, mc_req=0, mc_we=0, mc_addr=0, mc_wdata=0, assembly buffer=0.
  - While rst=1, combinational outputs are forced to 0: mem_rd_data, mem_rd_addr, mem_rd_enable, mem_stall.
  - Reset mid-access aborts the access; the controller sees mc_req drop.
- rdy=0: no state, index, buffer or mc_* register changes; combinational outputs still follow the current state.
- Length: B ops (1, 4, 6) = 1 byte; H ops (2, 5, 7) = 2 bytes; W ops (3, 8) = 4 bytes. No alignment check; the address simply increments per byte.
- IDLE:
  - op=none: mem_rd_* = ex_rd_*, mem_stall=0.
  - Memory op: mem_stall=1, mem_rd_enable=0.
  - At the edge: latch op, rd_addr, rd_enable and store_data; set mc_req=1, mc_we=(op>=6), mc_addr=ex_mem_addr, mc_wdata=store_data[7:0], idx=0; go to ACCESS.
- ACCESS:
  - mem_stall=1, mem_rd_enable=0.
  - On mc_done for a read: buffer byte idx <= mc_rdata.
  - If idx==len-1: mc_req<=0, go to DONE.
  - Otherwise: idx+1, mc_addr+1, mc_wdata=store_data byte idx+1.
  - mc_done while mc_req=0 is ignored.
- DONE (exactly 1 cycle):
  - mem_stall=0, mem_rd_addr=latched rd_addr.
  - mem_rd_enable = latched rd_enable for loads, 0 for stores.
  - mem_rd_data = LB/LH sign-extended from bit 7/15; LBU/LHU zero-extended; LW = {b3,b2,b1,b0}; stores 0.
  - Next edge goes to IDLE. Upstream advances on this edge, so the same instruction is not re-accepted.
- Latency with mc_done high on every ACCESS cycle:
  - LW: accept cycle + 4 ACCESS cycles stalled = 5 stall cycles; result in DONE on cycle 6.
  - LB: 2 stall cycles; result on cycle 3.
- Slow memory: stall extends indefinitely; no timeout.
- mc_addr wraps modulo 2^ADDR_WIDTH.
- Back-to-back memory ops: each takes its own IDLE→ACCESS→DONE sequence; there is no overlap.

Test Plan:
1. ex_mem_op=0, ex_rd_data=0x1234, rd_addr=5, enable=1 -> same cycle mem_rd_data=0x1234, rd_addr=5, rd_enable=1, mem_stall=0.
2. LW at 0x100, memory bytes 0x78,0x56,0x34,0x12, mc_done every cycle:
   - mc_addr steps 0x100..0x103; mem_stall high 5 cycles.
   - DONE cycle: mem_rd_data=0x12345678, rd_enable=1.
3. LB at 0x200 returning 0x80 -> DONE mem_rd_data=0xFFFFFF80; same with LBU -> 0x00000080. LH returning 0x00,0x80 -> 0xFFFF8000.
4. SW 0xAABBCCDD at 0x300 with mc_done after 2-cycle delays:
   - mc_we=1; mc_wdata sequence 0xDD,0xCC,0xBB,0xAA at 0x300..0x303.
   - DONE: rd_enable=0; mc_req low afterwards.
5. rdy=0 for 3 cycles during LW byte 2 -> mc_addr, idx and buffer frozen; final result still 0x12345678.
6. rst=1 during ACCESS of LH -> next cycle mc_req=0, state IDLE, all mem_rd_* and mem_stall =0; a subsequent LB completes normally.

Source files
------------

// File: rtl/mem_access.sv
// MEM stage: runs loads/stores as byte-serial transfers over an 8-bit memory port,
// assembles little-endian words, and passes non-memory results straight through.
module mem_access #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [31:0]           ex_rd_data,
    input  logic [4:0]            ex_rd_addr,
    input  logic                  ex_rd_enable,
    input  logic [3:0]            ex_mem_op,
    input  logic [ADDR_WIDTH-1:0] ex_mem_addr,
    input  logic [31:0]           ex_store_data,
    output logic [31:0]           mem_rd_data,
    output logic [4:0]            mem_rd_addr,
    output logic                  mem_rd_enable,
    output logic                  mem_stall,
    output logic                  mc_req,
    output logic                  mc_we,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [7:0]            mc_wdata,
    input  logic [7:0]            mc_rdata,
    input  logic                  mc_done
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                           OP_LBU = 4'd4, OP_LHU = 4'd5;

    state_t                r_state;
    logic [1:0]            r_idx;
    logic [3:0]            r_op;
    logic [4:0]            r_rd_addr;
    logic                  r_rd_enable;
    logic [31:0]           r_store_data;
    logic [3:0][7:0]       r_buf;
    logic                  r_mc_req;
    logic                  r_mc_we;
    logic [ADDR_WIDTH-1:0] r_mc_addr;
    logic [7:0]            r_mc_wdata;

    logic                  w_ex_is_mem;
    logic                  w_is_load;
    logic [1:0]            w_last_idx;
    logic [1:0]            w_next_idx;
    logic [31:0]           w_load_data;
    logic [7:0]            w_store_byte [4];

    // Index of the final byte for an op: 0 for byte ops, 1 for halfwords, 3 for words.
    function automatic logic [1:0] last_idx(input logic [3:0] op);
        case (op)
            4'd2, 4'd5, 4'd7: last_idx = 2'd1;
            4'd3, 4'd8:       last_idx = 2'd3;
            default:          last_idx = 2'd0;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
            assign w_store_byte[gi] = r_store_data[8*gi +: 8];
        end
    endgenerate

    assign w_ex_is_mem = (ex_mem_op >= 4'd1) && (ex_mem_op <= 4'd8);
    assign w_is_load   = (r_op >= OP_LB) && (r_op <= OP_LHU);
    assign w_last_idx  = last_idx(r_op);
    assign w_next_idx  = r_idx + 2'd1;

    assign mc_req   = r_mc_req;
    assign mc_we    = r_mc_we;
    assign mc_addr  = r_mc_addr;
    assign mc_wdata = r_mc_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_op         <= 4'd0;
            r_rd_addr    <= 5'd0;
            r_rd_enable  <= 1'b0;
            r_store_data <= 32'd0;
            r_buf        <= '0;
            r_mc_req     <= 1'b0;
            r_mc_we      <= 1'b0;
            r_mc_addr    <= '0;
            r_mc_wdata   <= 8'd0;
        end else if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (w_ex_is_mem) begin
                        r_op         <= ex_mem_op;
                        r_rd_addr    <= ex_rd_addr;
                        r_rd_enable  <= ex_rd_enable;
                        r_store_data <= ex_store_data;
                        r_idx        <= 2'd0;
                        r_mc_req     <= 1'b1;
                        r_mc_we      <= (ex_mem_op >= 4'd6);
                        r_mc_addr    <= ex_mem_addr;
                        r_mc_wdata   <= ex_store_data[7:0];
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mc_done && r_mc_req) begin
                        if (!r_mc_we) begin
                            r_buf[r_idx] <= mc_rdata;
                        end
                        if (r_idx == w_last_idx) begin
                            r_mc_req <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_mc_addr  <= r_mc_addr + ADDR_WIDTH'(1);
                            r_mc_wdata <= w_store_byte[w_next_idx];
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Only the bytes belonging to the current op are read; stale upper bytes are masked off.
    always_comb begin
        w_load_data = 32'd0;
        case (r_op)
            OP_LB:   w_load_data = {{24{r_buf[0][7]}}, r_buf[0]};
            OP_LH:   w_load_data = {{16{r_buf[1][7]}}, r_buf[1], r_buf[0]};
            OP_LW:   w_load_data = r_buf;
            OP_LBU:  w_load_data = {24'd0, r_buf[0]};
            OP_LHU:  w_load_data = {16'd0, r_buf[1], r_buf[0]};
            default: w_load_data = 32'd0;
        endcase
    end

    always_comb begin
        mem_rd_data   = 32'd0;
        mem_rd_addr   = 5'd0;
        mem_rd_enable = 1'b0;
        mem_stall     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    mem_rd_addr = ex_rd_addr;
                    if (w_ex_is_mem) begin
                        mem_stall = 1'b1;
                    end else begin
                        mem_rd_data   = ex_rd_data;
                        mem_rd_enable = ex_rd_enable;
                    end
                end
                S_ACCESS: begin
                    mem_stall   = 1'b1;
                    mem_rd_addr = r_rd_addr;
                end
                S_DONE: begin
                    mem_rd_addr   = r_rd_addr;
                    mem_rd_enable = r_rd_enable && w_is_load;
                    mem_rd_data   = w_is_load ? w_load_data : 32'd0;
                end
                default: begin
                    mem_stall = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte-addressed memory model with configurable response delay,
// directed scenarios followed by randomized loads, stores and pass-through ops.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [31:0] ex_rd_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_enable;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic [31:0] mem_rd_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_enable;
    logic        mem_stall;
    logic        mc_req, mc_we;
    logic [31:0] mc_addr;
    logic [7:0]  mc_wdata;
    logic [7:0]  mc_rdata = 8'd0;
    logic        mc_done = 1'b0;

    always #5 clk = ~clk;

    mem_access #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ex_rd_data(ex_rd_data), .ex_rd_addr(ex_rd_addr), .ex_rd_enable(ex_rd_enable),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
        .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
        .mem_stall(mem_stall), .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr),
        .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_done(mc_done)
    );

    logic [7:0]  mem [logic [31:0]];
    logic [40:0] log_q [$];
    int          resp_delay = 0;
    int          resp_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] last_data;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory controller: completes a byte resp_delay cycles after the request is seen.
    always @(negedge clk) begin
        mc_done = 1'b0;
        if (mc_req) begin
            if (resp_cnt >= resp_delay) begin
                mc_done  = 1'b1;
                mc_rdata = rd_byte(mc_addr);
                resp_cnt = 0;
            end else begin
                resp_cnt++;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    // Records every byte transfer the DUT actually consumes and commits writes.
    always @(posedge clk) begin
        if (!rst && rdy && mc_req && mc_done) begin
            log_q.push_back({mc_we, mc_addr, mc_wdata});
            if (mc_we) mem[mc_addr] = mc_wdata;
        end
    end

    task automatic pass_check(input logic [3:0] op);
        logic [31:0] d;
        logic [4:0]  a;
        logic        e;
        d = $urandom; a = 5'($urandom); e = 1'($urandom);
        @(negedge clk);
        ex_mem_op = op; ex_rd_data = d; ex_rd_addr = a; ex_rd_enable = e;
        #1;
        chk("pass_data", mem_rd_data, d);
        chk("pass_addr", 32'(mem_rd_addr), 32'(a));
        chk("pass_en", 32'(mem_rd_enable), 32'(e));
        chk("pass_stall", 32'(mem_stall), 32'd0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input int dly, input int freeze_at);
        int          len, exp_stall, stalls;
        bit          is_load;
        logic [4:0]  rda;
        logic        en;
        logic [7:0]  b [4];
        logic [31:0] exp_data, held;
        logic [7:0]  sb;

        len = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
              (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
        is_load = (op <= 4'd5);
        rda = 5'($urandom_range(1, 31));
        en  = 1'($urandom);
        for (int i = 0; i < 4; i++) b[i] = rd_byte(addr + 32'(i));
        case (op)
            4'd1:    exp_data = (b[0] >= 8'd128) ? 32'(b[0]) - 32'd256 : 32'(b[0]);
            4'd2:    exp_data = (b[1] >= 8'd128) ? 32'(b[0]) + 32'(b[1]) * 256 - 32'd65536
                                                 : 32'(b[0]) + 32'(b[1]) * 256;
            4'd3:    exp_data = 32'(b[0]) + 32'(b[1]) * 256 + 32'(b[2]) * 65536 + 32'(b[3]) * 16777216;
            4'd4:    exp_data = 32'(b[0]);
            4'd5:    exp_data = 32'(b[0]) + 32'(b[1]) * 256;
            default: exp_data = 32'd0;
        endcase
        exp_stall = 1 + len * (dly + 1) + ((freeze_at >= 0) ? 3 : 0);

        resp_delay = dly;
        log_q.delete();
        @(negedge clk);
        ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sdata;
        ex_rd_addr = rda; ex_rd_enable = en; ex_rd_data = $urandom;
        stalls = 0;
        forever begin
            #1;
            if (!mem_stall) break;
            stalls++;
            if (stalls > 300) break;
            if (stalls == freeze_at) begin
                rdy = 1'b0;
                held = mc_addr;
                repeat (3) begin
                    @(negedge clk); #1;
                    chk("frz_addr", mc_addr, held);
                    chk("frz_stall", 32'(mem_stall), 32'd1);
                    stalls++;
                end
                rdy = 1'b1;
            end
            @(negedge clk);
        end
        if (stalls > 300) begin
            chk("timeout", 32'(stalls), 32'(exp_stall));
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            ex_mem_op = 4'd0;
            return;
        end
        $display("[TB] op=%0d addr=%08h sdata=%08h dly=%0d stalls=%0d data=%08h",
                 op, addr, sdata, dly, stalls, mem_rd_data);
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        chk("done_addr", 32'(mem_rd_addr), 32'(rda));
        chk("done_en", 32'(mem_rd_enable), is_load ? 32'(en) : 32'd0);
        chk("done_data", mem_rd_data, exp_data);
        chk("done_req", 32'(mc_req), 32'd0);
        chk("xfer_count", 32'(log_q.size()), 32'(len));
        for (int i = 0; i < len && i < log_q.size(); i++) begin
            sb = sdata[8*i +: 8];
            chk("xfer_addr", log_q[i][39:8], addr + 32'(i));
            chk("xfer_we", 32'(log_q[i][40]), is_load ? 32'd0 : 32'd1);
            chk("xfer_wdata", 32'(log_q[i][7:0]), 32'(sb));
        end
        last_data = mem_rd_data;
        @(negedge clk);
        ex_mem_op = 4'd0;
        #1;
        chk("idle_req", 32'(mc_req), 32'd0);
        chk("idle_stall", 32'(mem_stall), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        ex_rd_data = 32'hDEADBEEF; ex_rd_addr = 5'd9; ex_rd_enable = 1'b1;
        ex_mem_op = 4'd0; ex_mem_addr = 32'h10; ex_store_data = 32'h55;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_data", mem_rd_data, 32'd0);
        chk("rst_addr", 32'(mem_rd_addr), 32'd0);
        chk("rst_en", 32'(mem_rd_enable), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_req", 32'(mc_req), 32'd0);
        chk("rst_we", 32'(mc_we), 32'd0);
        chk("rst_mc_addr", mc_addr, 32'd0);
        chk("rst_wdata", 32'(mc_wdata), 32'd0);
        rst = 1'b0;

        // Pass-through of a non-memory op in the same cycle
        @(negedge clk);
        ex_mem_op = 4'd0; ex_rd_data = 32'h1234; ex_rd_addr = 5'd5; ex_rd_enable = 1'b1;
        #1;
        chk("t1_data", mem_rd_data, 32'h1234);
        chk("t1_addr", 32'(mem_rd_addr), 32'd5);
        chk("t1_en", 32'(mem_rd_enable), 32'd1);
        chk("t1_stall", 32'(mem_stall), 32'd0);

        // LW with a response every cycle
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        run_op(4'd3, 32'h100, 32'h0, 0, -1);
        chk("t2_lw", last_data, 32'h12345678);

        // Sign and zero extension
        mem[32'h200] = 8'h80;
        run_op(4'd1, 32'h200, 32'h0, 0, -1);
        chk("t3_lb", last_data, 32'hFFFFFF80);
        run_op(4'd4, 32'h200, 32'h0, 0, -1);
        chk("t3_lbu", last_data, 32'h00000080);
        mem[32'h210] = 8'h00; mem[32'h211] = 8'h80;
        run_op(4'd2, 32'h210, 32'h0, 0, -1);
        chk("t3_lh", last_data, 32'hFFFF8000);

        // Slow store, then read it back
        run_op(4'd8, 32'h300, 32'hAABBCCDD, 2, -1);
        run_op(4'd3, 32'h300, 32'h0, 1, -1);
        chk("t4_readback", last_data, 32'hAABBCCDD);

        // Global enable dropped during byte 2 of a word load
        run_op(4'd3, 32'h100, 32'h0, 0, 4);
        chk("t5_lw_frozen", last_data, 32'h12345678);

        // Reset in the middle of a halfword load
        @(negedge clk);
        resp_delay = 3;
        ex_mem_op = 4'd2; ex_mem_addr = 32'h400; ex_rd_addr = 5'd7; ex_rd_enable = 1'b1;
        @(negedge clk); #1;
        chk("t6_in_access", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_stall", 32'(mem_stall), 32'd0);
        chk("t6_rst_en", 32'(mem_rd_enable), 32'd0);
        @(negedge clk); #1;
        chk("t6_req_drop", 32'(mc_req), 32'd0);
        rst = 1'b0;
        ex_mem_op = 4'd0; ex_rd_data = 32'd0; ex_rd_addr = 5'd0; ex_rd_enable = 1'b0;
        #1;
        chk("t6_idle_stall", 32'(mem_stall), 32'd0);
        chk("t6_idle_data", mem_rd_data, 32'd0);
        chk("t6_idle_en", 32'(mem_rd_enable), 32'd0);
        run_op(4'd1, 32'h200, 32'h0, 0, -1);
        chk("t6_lb_after", last_data, 32'hFFFFFF80);

        // Randomized mix, including address wrap and reserved opcodes
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            a = (i % 5 == 0) ? 32'hFFFF_FFFE : $urandom;
            if (i % 7 == 3) begin
                pass_check((i % 2 == 0) ? 4'd0 : 4'($urandom_range(9, 15)));
            end else begin
                run_op(4'($urandom_range(1, 8)), a, $urandom, $urandom_range(0, 2), -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
